udp_tx_arbiter: RTL and testbench
=================================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter NR, default 8, number of DDC requesters, legal range 1..8.
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles enforced between packets, legal range 1..255.
REQ-003 Parameter WDOG_CYCLES, default 2048, grant watchdog limit in tx_clock cycles.
REQ-004 tx_clock  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  radio running; low restricts grants to the response class.
REQ-007 req_rsp, req_cc, req_mic, req_wb  in  1 each  packet requests (discovery/erase/more response, C&C, mic, wideband).
REQ-008 req_ddc  in  NR  per-DDC packet request.
REQ-009 done  in  1  one-cycle pulse from the granted sender: packet fully handed to the UDP layer.
REQ-010 gnt_rsp, gnt_cc, gnt_mic, gnt_wb  out  1 each  one-hot grants.
REQ-011 gnt_ddc  out  NR  one-hot DDC grants.
REQ-012 port_ID  out  8  from-port offset of the current grant: 0 rsp, 1 CC, 2 mic, 3 WB, 11+i DDC i.
REQ-013 busy  out  1  high while any grant is held or GAP is active.
REQ-014 phy_ready  out  1  high when no DDC grant is held and req_ddc[0] is low.
REQ-015 abort  out  1  one-cycle pulse when a grant is revoked without done.

Function
REQ-016 FSM states: IDLE, GRANT, GAP.
REQ-017 IDLE: the winner among eligible requests is registered; grant and port_ID are asserted on the next edge, and the FSM moves to GRANT. Latency from a sampled req to its grant is 1 cycle.
REQ-018 Fixed priority, highest first: rsp > CC > mic > WB > DDC.
REQ-019 Eligibility with run=0: rsp only. With run=1: all classes; WB additionally requires wb_token=1.
REQ-020 DDC selection is round-robin from ddc_ptr upward, wrapping NR-1 to 0; ddc_ptr becomes winner+1 (mod NR) when a DDC is granted.
REQ-021 wb_token:
- Set when a DDC NR-1 grant ends, or when run=1 in IDLE with req_ddc all zero.
- Cleared when WB is granted.
REQ-022 GRANT: the grant is held until one of the following; all drop the grant on the next edge and go to GAP:
- done=1;
- the granted req falls (abandon; abort pulse);
- run falls while the grant is not rsp (abort pulse).
REQ-023 GAP: counts GAP_CYCLES cycles with no grant, then returns to IDLE. Requests arriving during GAP are evaluated in IDLE, never lost while held.
REQ-024 done outside GRANT is ignored; done and req-fall in the same cycle count as a normal completion (no abort).
REQ-025 Exactly one grant bit is high at any time, or none.
REQ-026 port_ID holds its last value in GAP and is 0 in IDLE.

Reset
REQ-027 reset_n low asynchronously forces:
- state=IDLE, all grants 0, port_ID=0, busy=0, abort=0;
- ddc_ptr=0, wb_token=0, gap and watchdog counters 0.
REQ-028 Reset mid-GRANT drops the grant immediately with no abort pulse; after release, arbitration restarts from ddc_ptr=0.

Configuration
REQ-029 Macro UDP_TX_WATCHDOG_EN defined: a counter runs in GRANT. Reaching WDOG_CYCLES without done revokes the grant, pulses abort, and enters GAP.
REQ-030 Macro UDP_TX_WATCHDOG_EN undefined: no counter is built, and a grant is held indefinitely until done, req fall or run fall.

Structure
REQ-031 Package udp_arb_pkg holds:
- the state enum;
- port offset constants (PORT_RSP=0, PORT_CC=1, PORT_MIC=2, PORT_WB=3, PORT_DDC_BASE=11);
- the default GAP_CYCLES and WDOG_CYCLES.
REQ-032 Sub-module rr_pick: a combinational NR-wide round-robin picker (inputs req vector and pointer; outputs one-hot and index), instantiated once.

Verification
REQ-033 run=1, req_cc and req_ddc[2] raised together -> gnt_cc next cycle, port_ID=1; after done and 4 GAP cycles -> gnt_ddc[2], port_ID=13.
REQ-034 NR=4, run=1, req_ddc=4'b1111 held, done after each grant -> grant order 0,1,2,3,0; with req_wb held, WB is granted once between DDC 3 and DDC 0.
REQ-035 run=0, req_mic and req_rsp raised -> only gnt_rsp is issued; mic waits; run rises -> gnt_mic after the rsp completes plus GAP.
REQ-036 gnt_ddc[1] held, run dropped -> gnt_ddc[1]=0 and abort=1 next cycle, then 4 GAP cycles, then IDLE.
REQ-037 UDP_TX_WATCHDOG_EN defined, WDOG_CYCLES=16, gnt_mic with no done -> abort at cycle 16 of GRANT; macro undefined -> grant still held at cycle 100.
REQ-038 reset_n pulsed low mid-GRANT -> all grants 0 in the same cycle, no abort; post-reset requests for DDC 0 and 3 -> DDC 0 granted first.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the UDP transmit arbiter: FSM states,
// from-port offsets and default timing parameters.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic [7:0] PORT_RSP      = 8'd0;
  localparam logic [7:0] PORT_CC       = 8'd1;
  localparam logic [7:0] PORT_MIC      = 8'd2;
  localparam logic [7:0] PORT_WB       = 8'd3;
  localparam logic [7:0] PORT_DDC_BASE = 8'd11;

  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_WDOG_CYCLES = 2048;

  function automatic logic [7:0] ddc_port(input logic [2:0] idx);
    return PORT_DDC_BASE + {5'd0, idx};
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NR-1 back to 0. Returns one-hot, index and a valid flag.
module rr_pick #(
  parameter int NR   = 8,
  parameter int IDXW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic [NR-1:0]   req,
  input  logic [IDXW-1:0] ptr,
  output logic [NR-1:0]   onehot,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  always_comb begin
    int j;
    logic [IDXW-1:0] jj;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < NR; k++) begin
      // ptr is always below NR, so one subtraction is enough to wrap
      j = int'(ptr) + k;
      if (j >= NR) j = j - NR;
      jj = IDXW'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-level transmit arbiter for the UDP sender: fixed-priority classes
// plus round-robin DDCs. Optional grant watchdog via UDP_TX_WATCHDOG_EN.
//
// state    | meaning
// ST_IDLE  | no grant; evaluate eligible requests, grant winner next edge
// ST_GRANT | one grant held until done, req fall, run fall or watchdog
// ST_GAP   | GAP_CYCLES enforced idle cycles, port_ID held
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NR          = 8,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic          tx_clock,
  input  logic          reset_n,
  input  logic          run,
  input  logic          req_rsp,
  input  logic          req_cc,
  input  logic          req_mic,
  input  logic          req_wb,
  input  logic [NR-1:0] req_ddc,
  input  logic          done,
  output logic          gnt_rsp,
  output logic          gnt_cc,
  output logic          gnt_mic,
  output logic          gnt_wb,
  output logic [NR-1:0] gnt_ddc,
  output logic [7:0]    port_ID,
  output logic          busy,
  output logic          phy_ready,
  output logic          abort
);

  localparam int              IDXW     = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR - 1);
  localparam logic [7:0]      GAP_LOAD = 8'(GAP_CYCLES - 1);

  arb_state_e      state;
  logic [IDXW-1:0] ddc_ptr;
  logic [IDXW-1:0] ddc_ptr_next;
  logic            wb_token;
  logic [7:0]      gap_cnt;

  logic            elig_cc, elig_mic, elig_wb;
  logic [NR-1:0]   elig_ddc;
  logic [NR-1:0]   ddc_onehot;
  logic [IDXW-1:0] ddc_idx;
  logic            ddc_valid;

  logic            granted_live;
  logic            run_drop;
  logic            wdog_expired;
  logic            grant_end;

  assign elig_cc  = run & req_cc;
  assign elig_mic = run & req_mic;
  assign elig_wb  = run & req_wb & wb_token;
  assign elig_ddc = run ? req_ddc : '0;

  rr_pick #(
    .NR   (NR),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req    (elig_ddc),
    .ptr    (ddc_ptr),
    .onehot (ddc_onehot),
    .idx    (ddc_idx),
    .valid  (ddc_valid)
  );

  assign ddc_ptr_next = (ddc_idx == LAST_IDX) ? '0 : ddc_idx + 1'b1;

  assign granted_live = (gnt_rsp & req_rsp) | (gnt_cc & req_cc) |
                        (gnt_mic & req_mic) | (gnt_wb & req_wb) |
                        (|(gnt_ddc & req_ddc));

  // The response class is the only one allowed while the radio is stopped
  assign run_drop  = ~run & ~gnt_rsp;
  assign grant_end = done | ~granted_live | run_drop | wdog_expired;

`ifdef UDP_TX_WATCHDOG_EN
  localparam int             WDW       = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LOAD = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] wdog_cnt;

  // Reloaded in IDLE, so it always starts full on the first GRANT cycle
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wdog_cnt <= WDOG_LOAD;
    end else if (state == ST_GRANT && wdog_cnt != '0) begin
      wdog_cnt <= wdog_cnt - 1'b1;
    end
  end

  assign wdog_expired = (state == ST_GRANT) && (wdog_cnt == '0);
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      gnt_rsp  <= 1'b0;
      gnt_cc   <= 1'b0;
      gnt_mic  <= 1'b0;
      gnt_wb   <= 1'b0;
      gnt_ddc  <= '0;
      port_ID  <= 8'd0;
      abort    <= 1'b0;
      ddc_ptr  <= '0;
      wb_token <= 1'b0;
      gap_cnt  <= 8'd0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run && (req_ddc == '0)) wb_token <= 1'b1;
          if (req_rsp) begin
            gnt_rsp <= 1'b1;
            port_ID <= PORT_RSP;
            state   <= ST_GRANT;
          end else if (elig_cc) begin
            gnt_cc  <= 1'b1;
            port_ID <= PORT_CC;
            state   <= ST_GRANT;
          end else if (elig_mic) begin
            gnt_mic <= 1'b1;
            port_ID <= PORT_MIC;
            state   <= ST_GRANT;
          end else if (elig_wb) begin
            gnt_wb   <= 1'b1;
            wb_token <= 1'b0;
            port_ID  <= PORT_WB;
            state    <= ST_GRANT;
          end else if (ddc_valid) begin
            gnt_ddc <= ddc_onehot;
            port_ID <= ddc_port(3'(ddc_idx));
            ddc_ptr <= ddc_ptr_next;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            // done wins over a simultaneous req fall / run fall / timeout
            abort <= ~done;
            if (gnt_ddc[NR-1]) wb_token <= 1'b1;
            gnt_rsp <= 1'b0;
            gnt_cc  <= 1'b0;
            gnt_mic <= 1'b0;
            gnt_wb  <= 1'b0;
            gnt_ddc <= '0;
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            port_ID <= 8'd0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign phy_ready = ~(|gnt_ddc) & ~req_ddc[0];

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (NR=4, GAP_CYCLES=4, WDOG_CYCLES=16).
module tb_udp_tx_arbiter;

  logic       tx_clock = 1'b0;
  logic       reset_n;
  logic       run;
  logic       req_rsp, req_cc, req_mic, req_wb;
  logic [3:0] req_ddc;
  logic       done;
  logic       gnt_rsp, gnt_cc, gnt_mic, gnt_wb;
  logic [3:0] gnt_ddc;
  logic [7:0] port_ID;
  logic       busy, phy_ready, abort;
  logic [7:0] gvec;

  int checks   = 0;
  int failures = 0;

  always #5 tx_clock = ~tx_clock;

  udp_tx_arbiter #(
    .NR          (4),
    .GAP_CYCLES  (4),
    .WDOG_CYCLES (16)
  ) dut (
    .tx_clock  (tx_clock),
    .reset_n   (reset_n),
    .run       (run),
    .req_rsp   (req_rsp),
    .req_cc    (req_cc),
    .req_mic   (req_mic),
    .req_wb    (req_wb),
    .req_ddc   (req_ddc),
    .done      (done),
    .gnt_rsp   (gnt_rsp),
    .gnt_cc    (gnt_cc),
    .gnt_mic   (gnt_mic),
    .gnt_wb    (gnt_wb),
    .gnt_ddc   (gnt_ddc),
    .port_ID   (port_ID),
    .busy      (busy),
    .phy_ready (phy_ready),
    .abort     (abort)
  );

  // bit0 rsp, bit1 cc, bit2 mic, bit3 wb, bits 7:4 ddc 3..0
  assign gvec = {gnt_ddc, gnt_wb, gnt_mic, gnt_cc, gnt_rsp};

  typedef struct {
    logic       run, rsp, cc, mic, wb;
    logic [3:0] ddc;
    logic [7:0] gnt;
    logic [7:0] port;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic clear_in();
    run     = 1'b0;
    req_rsp = 1'b0;
    req_cc  = 1'b0;
    req_mic = 1'b0;
    req_wb  = 1'b0;
    req_ddc = 4'b0000;
    done    = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(posedge tx_clock);
    @(negedge tx_clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_grant(input int limit, output int n);
    n = 0;
    while (gvec == 8'h00 && n < limit) begin
      step();
      n++;
    end
  endtask

  logic [7:0] rr_order [6];
  logic [7:0] exp_phy;
  int         n;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h01, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 8'h00, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h01, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 8'h02, 8'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h04, 8'd2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 8'h20, 8'd12};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h00, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'h80, 8'd14};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 8'h10, 8'd11};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 8'h01, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 8'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 8'h02, 8'd1};
    rr_order = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h08, 8'h10};

    // reset holds everything off even with requests driven
    reset_n = 1'b0;
    clear_in();
    run = 1'b1; req_rsp = 1'b1; req_ddc = 4'b1111;
    repeat (3) step();
    chk("reset_gnt", gvec, 8'h00);
    chk("reset_port", port_ID, 8'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_abort", abort, 1'b0);

    for (int i = 0; i < 12; i++) begin
      apply_reset();
      run = vecs[i].run; req_rsp = vecs[i].rsp; req_cc = vecs[i].cc;
      req_mic = vecs[i].mic; req_wb = vecs[i].wb; req_ddc = vecs[i].ddc;
      step();
      exp_phy = {7'd0, ~(|vecs[i].gnt[7:4]) & ~vecs[i].ddc[0]};
      chk($sformatf("vec%0d_gnt", i), gvec, vecs[i].gnt);
      chk($sformatf("vec%0d_port", i), port_ID, vecs[i].port);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].gnt != 8'h00);
      chk($sformatf("vec%0d_phy", i), phy_ready, exp_phy[0]);
    end

    // CC beats DDC2; DDC2 follows after done, 4 GAP cycles and one IDLE cycle
    apply_reset();
    run = 1'b1; req_cc = 1'b1; req_ddc = 4'b0100;
    step();
    chk("cc_first_gnt", gvec, 8'h02);
    chk("cc_first_port", port_ID, 8'd1);
    done = 1'b1; req_cc = 1'b0;
    step();
    done = 1'b0;
    chk("cc_done_gnt", gvec, 8'h00);
    chk("cc_done_noabort", abort, 1'b0);
    chk("gap_port_held", port_ID, 8'd1);
    repeat (3) step();
    chk("gap_busy_last", busy, 1'b1);
    chk("gap_gnt_none", gvec, 8'h00);
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_port", port_ID, 8'd0);
    step();
    chk("ddc2_gnt", gvec, 8'h40);
    chk("ddc2_port", port_ID, 8'd13);

    // round robin with WB inserted after DDC3
    apply_reset();
    run = 1'b1; req_ddc = 4'b1111; req_wb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(20, n);
      chk($sformatf("rr_order%0d", i), gvec, rr_order[i]);
      done = 1'b1;
      step();
      done = 1'b0;
    end

    // run low: only rsp; mic after rsp completes plus GAP
    apply_reset();
    req_mic = 1'b1; req_rsp = 1'b1;
    step();
    chk("rsp_only_gnt", gvec, 8'h01);
    step(); step();
    run = 1'b1;
    step();
    chk("rsp_held_run_up", gvec, 8'h01);
    done = 1'b1; req_rsp = 1'b0;
    step();
    done = 1'b0;
    chk("rsp_done_gnt", gvec, 8'h00);
    chk("rsp_done_noabort", abort, 1'b0);
    wait_grant(20, n);
    chk("mic_after_gap", gvec, 8'h04);
    chk("mic_latency", n, 5);

    // run falls during a DDC grant
    apply_reset();
    run = 1'b1; req_ddc = 4'b0010;
    step();
    chk("ddc1_gnt", gvec, 8'h20);
    step(); step();
    chk("ddc1_held", gvec, 8'h20);
    run = 1'b0;
    step();
    chk("runfall_gnt", gvec, 8'h00);
    chk("runfall_abort", abort, 1'b1);
    chk("runfall_port", port_ID, 8'd12);
    step();
    chk("abort_one_cycle", abort, 1'b0);
    step(); step();
    chk("runfall_gap_busy", busy, 1'b1);
    step();
    chk("runfall_idle", busy, 1'b0);
    step();
    chk("runfall_no_regrant", gvec, 8'h00);

    // request abandoned; done in GAP ignored
    apply_reset();
    run = 1'b1; req_mic = 1'b1;
    step();
    chk("mic_gnt", gvec, 8'h04);
    req_mic = 1'b0;
    step();
    chk("abandon_gnt", gvec, 8'h00);
    chk("abandon_abort", abort, 1'b1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("gap_done_abort", abort, 1'b0);
    chk("gap_done_busy", busy, 1'b1);

    // async reset mid-grant, pointer restarts at 0
    apply_reset();
    run = 1'b1; req_ddc = 4'b0010;
    step();
    chk("pre_reset_gnt", gvec, 8'h20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_gnt", gvec, 8'h00);
    chk("async_reset_abort", abort, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    req_ddc = 4'b1001;
    @(negedge tx_clock);
    reset_n = 1'b1;
    step();
    chk("post_reset_ddc0", gvec, 8'h10);
    chk("post_reset_port", port_ID, 8'd11);

    // grant watchdog
    apply_reset();
    run = 1'b1; req_mic = 1'b1;
    step();
    chk("wdog_mic_gnt", gvec, 8'h04);
`ifdef UDP_TX_WATCHDOG_EN
    for (int c = 2; c <= 16; c++) begin
      step();
      chk($sformatf("wdog_held_c%0d", c), gvec, 8'h04);
    end
    step();
    chk("wdog_revoke_gnt", gvec, 8'h00);
    chk("wdog_abort", abort, 1'b1);
`else
    n = 0;
    for (int c = 2; c <= 100; c++) begin
      step();
      if (abort) n++;
    end
    chk("nowdog_held_c100", gvec, 8'h04);
    chk("nowdog_no_abort", n, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
